// File: rtl/ras_ckpt_pkg.sv
// rtl/ras_ckpt_pkg.sv - shared sizing constants and operation decode for the return address stack
//
// RAS_ENTRIES      : default stack depth (power of two, at least 2)
// LOG_RAS_ENTRIES  : pointer width
// RAS_TARGET_WIDTH : stored return address width, PC[31:1]
// RAS_COUNT_WIDTH  : occupancy width, one bit wider than the pointer so "full" is representable
package ras_ckpt_pkg;

  localparam int RAS_ENTRIES      = 8;
  localparam int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);
  localparam int RAS_TARGET_WIDTH = 31;
  localparam int RAS_COUNT_WIDTH  = LOG_RAS_ENTRIES + 1;

  // One operation is applied per cycle; OP_REPLACE is a push and pop in the same cycle.
  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_RESTORE = 3'd4
  } ras_op_e;

  // Restore outranks push/pop; a push and pop together collapse into a replace of the top.
  function automatic ras_op_e ras_decode_op(input logic restore_v,
                                            input logic push_v,
                                            input logic pop_v);
    ras_op_e op;
    op = OP_NONE;
    if (restore_v) begin
      op = OP_RESTORE;
    end else if (push_v && pop_v) begin
      op = OP_REPLACE;
    end else if (push_v) begin
      op = OP_PUSH;
    end else if (pop_v) begin
      op = OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - checkpointable circular return address stack
//
// CLK           : clock
// RST           : synchronous active-high reset, clears pointer, count and all entries
// push_valid    : call predicted, push push_target
// push_target   : return address to push
// pop_valid     : return predicted, pop the top
// restore_valid : mispredict rollback to restore_ptr / restore_count (highest priority)
// restore_ptr   : checkpointed top pointer
// restore_count : checkpointed occupancy, clamped to RAS_ENTRIES
// top_valid     : stack not empty
// top_target    : entry at the top pointer
// ckpt_ptr      : current top pointer, for checkpointing
// ckpt_count    : current occupancy, for checkpointing
module ras_ckpt #(
  parameter int  RAS_ENTRIES      = ras_ckpt_pkg::RAS_ENTRIES,
  parameter int  RAS_TARGET_WIDTH = ras_ckpt_pkg::RAS_TARGET_WIDTH,
  localparam int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES),
  localparam int RAS_COUNT_WIDTH  = LOG_RAS_ENTRIES + 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_ENTRIES-1:0]  restore_ptr,
  input  logic [RAS_COUNT_WIDTH-1:0]  restore_count,
  output logic                        top_valid,
  output logic [RAS_TARGET_WIDTH-1:0] top_target,
  output logic [LOG_RAS_ENTRIES-1:0]  ckpt_ptr,
  output logic [RAS_COUNT_WIDTH-1:0]  ckpt_count
);

  localparam logic [RAS_COUNT_WIDTH-1:0] COUNT_FULL  = RAS_COUNT_WIDTH'(RAS_ENTRIES);
  localparam logic [RAS_COUNT_WIDTH-1:0] COUNT_EMPTY = '0;

  logic [RAS_TARGET_WIDTH-1:0] entries_q [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0]  ptr_q, ptr_d;
  logic [RAS_COUNT_WIDTH-1:0]  count_q, count_d;

  logic                        wr_en;
  logic [LOG_RAS_ENTRIES-1:0]  wr_idx;
  ras_ckpt_pkg::ras_op_e       op;

  // Reads are straight off the registers: zero-cycle latency.
  assign top_valid  = (count_q != COUNT_EMPTY);
  assign top_target = entries_q[ptr_q];
  assign ckpt_ptr   = ptr_q;
  assign ckpt_count = count_q;

  always_comb begin
    op      = ras_ckpt_pkg::ras_decode_op(restore_valid, push_valid, pop_valid);
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;

    case (op)
      ras_ckpt_pkg::OP_RESTORE: begin
        // Entries are left alone; anything overwritten since the checkpoint stays overwritten.
        ptr_d   = restore_ptr;
        count_d = (restore_count > COUNT_FULL) ? COUNT_FULL : restore_count;
      end
      ras_ckpt_pkg::OP_REPLACE: begin
        // Return immediately followed by a call: the top is replaced in place.
        wr_en  = 1'b1;
        wr_idx = ptr_q;
        if (count_q == COUNT_EMPTY) begin
          count_d = count_q + 1'b1;
        end
      end
      ras_ckpt_pkg::OP_PUSH: begin
        // Pointer wraps naturally; when full the oldest entry is overwritten silently.
        wr_en  = 1'b1;
        wr_idx = ptr_q + 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (count_q != COUNT_FULL) begin
          count_d = count_q + 1'b1;
        end
      end
      ras_ckpt_pkg::OP_POP: begin
        // Pointer moves even when empty so it stays in step with the fetch path.
        ptr_d = ptr_q - 1'b1;
        if (count_q != COUNT_EMPTY) begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (wr_en) begin
        entries_q[wr_idx] <= push_target;
      end
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// tb/tb_ras_ckpt.sv - self-checking bench for ras_ckpt against a behavioural stack model
module tb_ras_ckpt;
  import ras_ckpt_pkg::*;

  localparam int N  = RAS_ENTRIES;
  localparam int W  = RAS_TARGET_WIDTH;
  localparam int LW = LOG_RAS_ENTRIES;
  localparam int CW = RAS_COUNT_WIDTH;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          push_valid = 1'b0;
  logic [W-1:0]  push_target = '0;
  logic          pop_valid = 1'b0;
  logic          restore_valid = 1'b0;
  logic [LW-1:0] restore_ptr = '0;
  logic [CW-1:0] restore_count = '0;
  logic          top_valid;
  logic [W-1:0]  top_target;
  logic [LW-1:0] ckpt_ptr;
  logic [CW-1:0] ckpt_count;

  ras_ckpt dut (
    .CLK           (CLK),
    .RST           (RST),
    .push_valid    (push_valid),
    .push_target   (push_target),
    .pop_valid     (pop_valid),
    .restore_valid (restore_valid),
    .restore_ptr   (restore_ptr),
    .restore_count (restore_count),
    .top_valid     (top_valid),
    .top_target    (top_target),
    .ckpt_ptr      (ckpt_ptr),
    .ckpt_count    (ckpt_count)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a plain array with integer pointer/occupancy.
  int m_stk [N];
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit push, input bit pop, input bit restore,
                              input int tgt, input int rptr, input int rcnt);
    if (rst) begin
      foreach (m_stk[i]) m_stk[i] = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      m_known = 1'b1;
    end else if (restore) begin
      m_ptr = rptr % N;
      m_cnt = (rcnt > N) ? N : rcnt;
    end else if (push && pop) begin
      m_stk[m_ptr] = tgt;
      if (m_cnt == 0) m_cnt = 1;
    end else if (push) begin
      m_ptr = (m_ptr + 1) % N;
      m_stk[m_ptr] = tgt;
      m_cnt = (m_cnt + 1 > N) ? N : m_cnt + 1;
    end else if (pop) begin
      m_ptr = (m_ptr + N - 1) % N;
      m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
    end
  endtask

  // Outputs are sampled on the falling edge, well away from the update edge.
  always @(negedge CLK) begin
    if (m_known) begin
      check("model_top_valid",  32'(top_valid),  32'(m_cnt != 0));
      check("model_top_target", 32'(top_target), 32'(m_stk[m_ptr]));
      check("model_ckpt_ptr",   32'(ckpt_ptr),   32'(m_ptr));
      check("model_ckpt_count", 32'(ckpt_count), 32'(m_cnt));
    end
  end

  task automatic step(input bit rst, input bit push, input bit pop, input bit restore,
                      input int tgt, input int rptr, input int rcnt);
    RST           = rst;
    push_valid    = push;
    pop_valid     = pop;
    restore_valid = restore;
    push_target   = W'(tgt);
    restore_ptr   = LW'(rptr);
    restore_count = CW'(rcnt);
    @(posedge CLK);
    model_update(rst, push, pop, restore, tgt, rptr, rcnt);
    #2;
    RST           = 1'b0;
    push_valid    = 1'b0;
    pop_valid     = 1'b0;
    restore_valid = 1'b0;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_push(input int t);
    step(0, 1, 0, 0, t, 0, 0);
  endtask
  task automatic do_pop();
    step(0, 0, 1, 0, 0, 0, 0);
  endtask

  // Hand-computed expectations; tgt < 0 skips the target comparison.
  task automatic expect_state(input string tag, input int ptr, input int cnt, input int tv, input int tgt);
    check({tag, "_ptr"},   32'(ckpt_ptr),   32'(ptr));
    check({tag, "_count"}, 32'(ckpt_count), 32'(cnt));
    check({tag, "_valid"}, 32'(top_valid),  32'(tv));
    if (tgt >= 0) check({tag, "_target"}, 32'(top_target), 32'(tgt));
  endtask

  initial begin
    int sp;
    int sc;
    do_reset();
    do_reset();
    expect_state("reset", 0, 0, 0, 0);

    // Basic LIFO order
    do_push(32'h100);
    do_push(32'h200);
    do_push(32'h300);
    expect_state("abc_push", 3, 3, 1, 32'h300);
    do_pop();
    expect_state("abc_pop1", 2, 2, 1, 32'h200);
    do_pop();
    expect_state("abc_pop2", 1, 1, 1, 32'h100);
    do_pop();
    expect_state("abc_pop3", 0, 0, 0, -1);

    // Overflow: 1..10 at depth 8 keeps the newest eight
    do_reset();
    for (int k = 1; k <= 10; k++) do_push(k);
    expect_state("ovf_full", 2, 8, 1, 10);
    for (int k = 1; k <= 7; k++) begin
      do_pop();
      check("ovf_pop_target", 32'(top_target), 32'(10 - k));
    end
    do_pop();
    expect_state("ovf_drained", 2, 0, 0, -1);

    // Underflow moves the pointer but not the count
    do_reset();
    do_pop();
    expect_state("under_pop", 7, 0, 0, -1);
    do_push(32'h55);
    expect_state("under_push", 0, 1, 1, 32'h55);

    // Simultaneous push and pop replaces the top
    do_reset();
    do_push(32'h10);
    step(0, 1, 1, 0, 32'h20, 0, 0);
    expect_state("replace", 1, 1, 1, 32'h20);

    // Replace on an empty stack makes it non-empty
    do_reset();
    step(0, 1, 1, 0, 32'h33, 0, 0);
    expect_state("replace_empty", 0, 1, 1, 32'h33);

    // Checkpoint, speculate, restore: the overwritten entry stays corrupted
    do_reset();
    do_push(32'h1);
    do_push(32'h2);
    sp = int'(ckpt_ptr);
    sc = int'(ckpt_count);
    check("ckpt_ptr_captured", 32'(sp), 32'd2);
    check("ckpt_count_captured", 32'(sc), 32'd2);
    do_pop();
    do_push(32'h9);
    step(0, 0, 0, 1, 0, sp, sc);
    expect_state("restore", 2, 2, 1, 32'h9);

    // Restore beats push; entry 5 was cleared by reset and is not written
    step(0, 1, 0, 1, 32'hAA, 5, 3);
    expect_state("restore_push", 5, 3, 1, 0);

    // Restore count above depth is clamped
    step(0, 0, 0, 1, 0, 1, 15);
    expect_state("restore_clamp", 1, 8, 1, 32'h1);

    // Reset beats restore and wipes history
    step(1, 1, 1, 1, 32'h77, 6, 4);
    expect_state("rst_restore", 0, 0, 0, 0);
    do_push(32'h44);
    do_pop();
    do_pop();
    step(0, 0, 0, 1, 0, 2, 2);
    expect_state("rst_history", 2, 2, 1, 0);

    // Mixed traffic checked cycle by cycle against the model
    for (int k = 0; k < 60; k++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: do_push(int'($urandom_range(1, 32'h7fff)));
        3, 4, 5: do_pop();
        6:       step(0, 1, 1, 0, int'($urandom_range(1, 32'h7fff)), 0, 0);
        7:       step(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1, 32'h1234,
                      int'($urandom_range(0, N - 1)), int'($urandom_range(0, 15)));
        8:       step(0, 0, 0, 0, 0, 0, 0);
        default: if (k == 45) do_reset(); else do_push(k);
      endcase
    end

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
